// File: rtl/merge_stream_buffer_if.sv
// Pixel stream bundle between the merge tree, the buffer and the consumer.
// slave: buffer side (pixel in, tagged pixel out); master: producer/consumer side.
interface merge_stream_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = 5,
    parameter int COL_W      = 8
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] pxl_in;
    logic                  ready_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] pxl_out;
    logic [CH_W-1:0]       ch_out;
    logic [COL_W-1:0]      col_out;
    logic                  last_col;
    logic                  frame_end;

    modport slave (
        input  valid_in, pxl_in, ready_in,
        output valid_out, pxl_out, ch_out, col_out, last_col, frame_end
    );

    modport master (
        output valid_in, pxl_in, ready_in,
        input  valid_out, pxl_out, ch_out, col_out, last_col, frame_end
    );
endinterface

// File: rtl/merge_stream_buffer.sv
// Merge-tree output buffer: tags pixels with ch/col/row position, stores them in a FIFO.
// Ports: clk, reset (async active-low), bus (stream in/out), fill (occupancy), overflow (sticky drop).
module merge_stream_buffer #(
    parameter int D          = 220,
    parameter int NCH        = 32,
    parameter int ROWS       = 220,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    merge_stream_buffer_if.slave   bus,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int COLW = (D > 1) ? $clog2(D) : 1;
    localparam int ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef struct packed {
        logic                  frame_end;
        logic                  last_col;
        logic [COLW-1:0]       col;
        logic [CHW-1:0]        ch;
        logic [DATA_WIDTH-1:0] pxl;
    } word_t;

    logic [COLW-1:0] col_q;
    logic [CHW-1:0]  ch_q;
    logic [ROWW-1:0] row_q;
    logic            col_wrap;
    logic            ch_wrap;
    logic            row_wrap;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_next;
    logic [AW:0] avail;
    logic        full;
    logic        pop;
    logic        wr;
    logic        vout_q;
    word_t       out_q;
    word_t       wr_word;
    word_t       mem [DEPTH];

    assign col_wrap = (col_q == COLW'(D - 1));
    assign ch_wrap  = (ch_q == CHW'(NCH - 1));
    assign row_wrap = (row_q == ROWW'(ROWS - 1));

    assign fill = wr_ptr - rd_ptr;
    assign full = (fill == (AW + 1)'(DEPTH));
    assign pop  = vout_q && bus.ready_in;
    assign wr   = bus.valid_in && (!full || pop);

    // Entries that existed before this edge and survive the pop;
    // a word written on this same edge is never visible yet.
    assign avail   = fill - (AW + 1)'(pop);
    assign rd_next = rd_ptr + (AW + 1)'(pop);

    always_comb begin
        wr_word           = '0;
        wr_word.pxl       = bus.pxl_in;
        wr_word.ch        = ch_q;
        wr_word.col       = col_q;
        wr_word.last_col  = col_wrap;
        wr_word.frame_end = col_wrap && ch_wrap && row_wrap;
    end

    // Position counters track every upstream pixel, dropped or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            ch_q  <= '0;
            row_q <= '0;
        end else if (bus.valid_in) begin
            col_q <= col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap) begin
                ch_q <= ch_wrap ? '0 : ch_q + 1'b1;
                if (ch_wrap) begin
                    row_q <= row_wrap ? '0 : row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    // The head entry stays in the FIFO while presented; it leaves on pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            vout_q   <= 1'b0;
            out_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (bus.valid_in && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (!vout_q || pop) begin
                vout_q <= (avail != '0);
                if (avail != '0) begin
                    out_q <= mem[rd_next[AW-1:0]];
                end
            end
        end
    end

    assign bus.valid_out = vout_q;
    assign bus.pxl_out   = out_q.pxl;
    assign bus.ch_out    = out_q.ch;
    assign bus.col_out   = out_q.col;
    assign bus.last_col  = out_q.last_col;
    assign bus.frame_end = out_q.frame_end;
endmodule

// File: tb/tb_merge_stream_buffer.sv
// Scoreboard bench for merge_stream_buffer (D=4, NCH=2, ROWS=2, DEPTH=8).
// Model issues expected tagged words; negedge monitor checks handshakes.
module tb_merge_stream_buffer;
    localparam int D     = 4;
    localparam int NCH   = 2;
    localparam int ROWS  = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] p;
        int            ch;
        int            col;
        bit            lc;
        bit            fe;
    } exp_t;

    logic       clk = 0;
    logic       reset;
    logic [3:0] fill;
    logic       overflow;

    merge_stream_buffer_if #(.DATA_WIDTH(DW), .CH_W(1), .COL_W(2)) bus ();

    merge_stream_buffer #(
        .D(D), .NCH(NCH), .ROWS(ROWS), .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .fill(fill),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    int m_n    = 0;
    int m_cnt  = 0;
    bit m_vout = 0;
    bit m_ovf  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pixel n carries col n%D, ch (n/D)%NCH, row (n/(D*NCH))%ROWS.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n    = 0;
            m_cnt  = 0;
            m_vout = 0;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            bit   pop_m;
            bit   acc;
            int   pre;
            exp_t e;
            pop_m = m_vout && bus.ready_in;
            pre   = m_cnt;
            acc   = bus.valid_in && (pre < DEPTH || pop_m);
            if (acc) begin
                e.p   = bus.pxl_in;
                e.col = m_n % D;
                e.ch  = (m_n / D) % NCH;
                e.lc  = (e.col == D - 1);
                e.fe  = e.lc && (e.ch == NCH - 1) && (((m_n / (D * NCH)) % ROWS) == ROWS - 1);
                exp_q.push_back(e);
            end
            if (bus.valid_in && !acc) m_ovf = 1;
            if (bus.valid_in) m_n++;
            m_cnt  = pre - int'(pop_m) + int'(acc);
            m_vout = (pre - int'(pop_m)) > 0;
        end
    end

    logic          held = 0;
    logic [DW-1:0] h_p;
    logic [1:0]    h_col;
    logic          h_ch;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_valid", bus.valid_out, 0);
            chk("rst_fill", fill, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_pxl", bus.pxl_out, 0);
            chk("rst_tags", {bus.ch_out, bus.col_out, bus.last_col, bus.frame_end}, 0);
            held = 0;
        end else begin
            chk("valid_out", bus.valid_out, m_vout);
            chk("fill", fill, m_cnt);
            chk("overflow", overflow, m_ovf);
            if (held) begin
                chk("hold_pxl", bus.pxl_out, h_p);
                chk("hold_col", bus.col_out, h_col);
                chk("hold_ch", bus.ch_out, h_ch);
            end
            if (bus.valid_out && bus.ready_in) begin
                chk("sb_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pxl_out", bus.pxl_out, e.p);
                    chk("ch_out", bus.ch_out, e.ch);
                    chk("col_out", bus.col_out, e.col);
                    chk("last_col", bus.last_col, e.lc);
                    chk("frame_end", bus.frame_end, e.fe);
                end
            end
            held  = bus.valid_out && !bus.ready_in;
            h_p   = bus.pxl_out;
            h_col = bus.col_out;
            h_ch  = bus.ch_out;
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] p, input logic r);
        bus.valid_in = v;
        bus.pxl_in   = p;
        bus.ready_in = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 reset = 0;
        #1;
        chk("arst_fill", fill, 0);
        chk("arst_valid", bus.valid_out, 0);
        chk("arst_ovf", overflow, 0);
        repeat (2) begin
            bus.valid_in = 1'($urandom);
            bus.pxl_in   = $urandom;
            @(posedge clk);
            #2;
        end
        bus.valid_in = 0;
        #1 reset = 1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int sent;
        bus.valid_in = 0;
        bus.pxl_in   = 0;
        bus.ready_in = 0;
        reset        = 1;
        #1 reset = 0;

        repeat (4) begin
            bus.valid_in = 1'($urandom);
            bus.pxl_in   = $urandom;
            bus.ready_in = 1'($urandom);
            @(posedge clk);
            #2;
        end
        bus.valid_in = 0;
        #1 reset = 1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 16; i++) cyc(1, i, 1);
        repeat (4) cyc(0, 0, 1);

        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 100 + i, 0);
        chk("t3_fill", fill, 8);
        chk("t3_ovf", overflow, 1);
        repeat (10) cyc(0, 0, 1);
        cyc(1, 200, 1);
        repeat (3) cyc(0, 0, 1);

        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 300 + i, 0);
        chk("t4_full", fill, 8);
        for (int i = 0; i < 4; i++) cyc(1, 400 + i, 1);
        chk("t4_fill", fill, 8);
        chk("t4_ovf", overflow, 0);
        repeat (12) cyc(0, 0, 1);

        sent = 0;
        while (sent < 1000) begin
            logic v;
            v = 1'($urandom);
            cyc(v, $urandom, ($urandom % 4) != 0);
            if (v) sent++;
        end
        repeat (20) cyc(0, 0, 1);

        do_reset();
        for (int i = 0; i < 32; i++) cyc(1, 500 + i, 1);
        repeat (3) cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 600 + i, 0);
        chk("t6_fill", fill, 5);
        do_reset();
        cyc(1, 700, 1);
        repeat (4) cyc(0, 0, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
